// File: rtl/mem_stage_ctrl.sv
// Memory pipeline stage for a variable-latency data memory.
// Issues a one-cycle request, stalls the pipe until mem_done, keeps the
// returned data across instruction-side freezes and registers MEM/WB.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no access outstanding; a new access issues mem_req here
// WAIT   | request sent, waiting for mem_done; pipeline held
// HOLD   | data returned while fetch stalled; replay hold register
module mem_stage_ctrl #(
  parameter int DW = 16,
  parameter int AW = 16,
  parameter int RW = 3,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] alu_exmem,
  input  logic [DW-1:0] st_data_exmem,
  input  logic          mem_read_exmem,
  input  logic          mem_write_exmem,
  input  logic          reg_write_exmem,
  input  logic          mem_to_reg_exmem,
  input  logic [RW-1:0] wr_reg_exmem,
  input  logic          squash,
  input  logic          halt_exmem,
  input  logic          dump_exmem,
  input  logic          stall_instr,
  output logic          mem_req,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_dump,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_done,
  input  logic          mem_err,
  output logic          stall_data,
  output logic [DW-1:0] rdata_memwb,
  output logic [DW-1:0] alu_memwb,
  output logic          reg_write_memwb,
  output logic          mem_to_reg_memwb,
  output logic [RW-1:0] wr_reg_memwb,
  output logic          err,
  output logic [CW-1:0] stall_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] hold_q, hold_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [DW-1:0] alu_q, alu_d;
  logic          reg_write_q, reg_write_d;
  logic          mem_to_reg_q, mem_to_reg_d;
  logic [RW-1:0] wr_reg_q, wr_reg_d;
  logic          err_q, err_d;
  logic [CW-1:0] stall_cnt_q, stall_cnt_d;

  logic          access;
  logic          advance;
  logic          done_wait;
  logic [DW-1:0] rdata_src;

  // Halted stores are dropped; a squash kills any access type.
  assign access  = (mem_read_exmem | (mem_write_exmem & ~halt_exmem)) & ~squash;
  assign advance = ~stall_data & ~stall_instr;

  assign mem_wr    = mem_req & mem_write_exmem;
  assign mem_addr  = alu_exmem[AW-1:0];
  assign mem_wdata = st_data_exmem;
  assign mem_dump  = dump_exmem;

  // FSM next state plus request/stall outputs; both forced low during reset.
  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    stall_data = 1'b0;
    done_wait  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (access) begin
          mem_req    = 1'b1;
          stall_data = 1'b1;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_done) begin
          done_wait = 1'b1;
          state_d   = stall_instr ? S_HOLD : S_IDLE;
        end else begin
          stall_data = 1'b1;
        end
      end
      S_HOLD: begin
        if (!stall_instr) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (rst) begin
      mem_req    = 1'b0;
      stall_data = 1'b0;
      done_wait  = 1'b0;
    end
  end

  // Hold register, MEM/WB next values, sticky error and saturating stall counter.
  always_comb begin
    hold_d = done_wait ? mem_rdata : hold_q;

    rdata_src = '0;
    if (done_wait)               rdata_src = mem_rdata;
    else if (state_q == S_HOLD)  rdata_src = hold_q;

    rdata_d      = rdata_q;
    alu_d        = alu_q;
    reg_write_d  = reg_write_q;
    mem_to_reg_d = mem_to_reg_q;
    wr_reg_d     = wr_reg_q;
    if (advance) begin
      rdata_d      = rdata_src;
      alu_d        = alu_exmem;
      reg_write_d  = reg_write_exmem & ~squash;
      mem_to_reg_d = mem_to_reg_exmem;
      wr_reg_d     = wr_reg_exmem;
    end

    err_d = err_q | (done_wait & mem_err);

    stall_cnt_d = stall_cnt_q;
    if (stall_data && (stall_cnt_q != {CW{1'b1}})) stall_cnt_d = stall_cnt_q + CW'(1);
  end

  // State and pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      hold_q       <= '0;
      rdata_q      <= '0;
      alu_q        <= '0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      wr_reg_q     <= '0;
      err_q        <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      rdata_q      <= rdata_d;
      alu_q        <= alu_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      wr_reg_q     <= wr_reg_d;
      err_q        <= err_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign rdata_memwb      = rdata_q;
  assign alu_memwb        = alu_q;
  assign reg_write_memwb  = reg_write_q;
  assign mem_to_reg_memwb = mem_to_reg_q;
  assign wr_reg_memwb     = wr_reg_q;
  assign err              = err_q;
  assign stall_cnt        = stall_cnt_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: a vector table for single-instruction
// behaviour plus hand-written multi-cycle sequences.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] alu_exmem, st_data_exmem;
  logic        mem_read_exmem, mem_write_exmem, reg_write_exmem, mem_to_reg_exmem;
  logic [2:0]  wr_reg_exmem;
  logic        squash, halt_exmem, dump_exmem, stall_instr;
  logic [15:0] mem_rdata;
  logic        mem_done, mem_err;

  logic        mem_req, mem_wr, mem_dump, stall_data;
  logic [15:0] mem_addr, mem_wdata, rdata_memwb, alu_memwb;
  logic        reg_write_memwb, mem_to_reg_memwb, err;
  logic [2:0]  wr_reg_memwb;
  logic [15:0] stall_cnt;

  logic        mem_req2, mem_wr2, mem_dump2, stall_data2;
  logic [15:0] mem_addr2, mem_wdata2, rdata_memwb2, alu_memwb2;
  logic        reg_write_memwb2, mem_to_reg_memwb2, err2;
  logic [2:0]  wr_reg_memwb2;
  logic [1:0]  stall_cnt2;

  int n_tests = 0;
  int n_fail  = 0;
  int req_cnt = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.DW(16), .AW(16), .RW(3), .CW(16)) dut (
    .clk(clk), .rst(rst), .alu_exmem(alu_exmem), .st_data_exmem(st_data_exmem),
    .mem_read_exmem(mem_read_exmem), .mem_write_exmem(mem_write_exmem),
    .reg_write_exmem(reg_write_exmem), .mem_to_reg_exmem(mem_to_reg_exmem),
    .wr_reg_exmem(wr_reg_exmem), .squash(squash), .halt_exmem(halt_exmem),
    .dump_exmem(dump_exmem), .stall_instr(stall_instr), .mem_req(mem_req),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_dump(mem_dump),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_err(mem_err),
    .stall_data(stall_data), .rdata_memwb(rdata_memwb), .alu_memwb(alu_memwb),
    .reg_write_memwb(reg_write_memwb), .mem_to_reg_memwb(mem_to_reg_memwb),
    .wr_reg_memwb(wr_reg_memwb), .err(err), .stall_cnt(stall_cnt)
  );

  mem_stage_ctrl #(.DW(16), .AW(16), .RW(3), .CW(2)) dut2 (
    .clk(clk), .rst(rst), .alu_exmem(alu_exmem), .st_data_exmem(st_data_exmem),
    .mem_read_exmem(mem_read_exmem), .mem_write_exmem(mem_write_exmem),
    .reg_write_exmem(reg_write_exmem), .mem_to_reg_exmem(mem_to_reg_exmem),
    .wr_reg_exmem(wr_reg_exmem), .squash(squash), .halt_exmem(halt_exmem),
    .dump_exmem(dump_exmem), .stall_instr(stall_instr), .mem_req(mem_req2),
    .mem_wr(mem_wr2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_dump(mem_dump2),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_err(mem_err),
    .stall_data(stall_data2), .rdata_memwb(rdata_memwb2), .alu_memwb(alu_memwb2),
    .reg_write_memwb(reg_write_memwb2), .mem_to_reg_memwb(mem_to_reg_memwb2),
    .wr_reg_memwb(wr_reg_memwb2), .err(err2), .stall_cnt(stall_cnt2)
  );

  always @(posedge clk) if (mem_req === 1'b1) req_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic rd, wr, halt, sq;
    logic [15:0] alu, st;
    logic regw, m2r;
    logic [2:0] wreg;
    logic [15:0] rdin;
    logic e_req, e_wr, e_stall;
    logic [15:0] e_rdata;
    logic e_regw;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    alu_exmem = '0; st_data_exmem = '0;
    mem_read_exmem = 1'b0; mem_write_exmem = 1'b0;
    reg_write_exmem = 1'b0; mem_to_reg_exmem = 1'b0; wr_reg_exmem = '0;
    squash = 1'b0; halt_exmem = 1'b0; dump_exmem = 1'b0; stall_instr = 1'b0;
    mem_rdata = '0; mem_done = 1'b0; mem_err = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive_load(input logic [15:0] addr, input logic [2:0] wreg);
    clear_inputs();
    mem_read_exmem = 1'b1; reg_write_exmem = 1'b1; mem_to_reg_exmem = 1'b1;
    alu_exmem = addr; wr_reg_exmem = wreg;
  endtask

  initial begin
    int stall_n;
    int req_base;
    int exp_cnt;

    rst = 1'b1;
    clear_inputs();

    //          rd    wr    halt  sq    alu       st        regw  m2r   wreg  rdin      req   wr    stall rdata     regw
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h1111, 16'h0000, 1'b1, 1'b0, 3'd3, 16'hFFFF, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000, 1'b1, 1'b1, 3'd5, 16'h5A5A, 1'b1, 1'b0, 1'b1, 16'h5A5A, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0020, 16'h1234, 1'b0, 1'b0, 3'd0, 16'h7777, 1'b1, 1'b1, 1'b1, 16'h7777, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0020, 16'h1234, 1'b0, 1'b0, 3'd0, 16'h0BAD, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0050, 16'h0000, 1'b1, 1'b1, 3'd2, 16'h9999, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0060, 16'h5555, 1'b1, 1'b0, 3'd7, 16'h1357, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0070, 16'h0000, 1'b1, 1'b1, 3'd1, 16'hC0DE, 1'b1, 1'b0, 1'b1, 16'hC0DE, 1'b1};

    // Reset state, including request/stall forced low while rst is high.
    mem_read_exmem = 1'b1;
    @(negedge clk); #1;
    check("rst_req", mem_req, 0);
    check("rst_stall", stall_data, 0);
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    dump_exmem = 1'b1;
    #1;
    check("reset_rdata", rdata_memwb, 0);
    check("reset_alu", alu_memwb, 0);
    check("reset_regw", reg_write_memwb, 0);
    check("reset_m2r", mem_to_reg_memwb, 0);
    check("reset_wreg", wr_reg_memwb, 0);
    check("reset_err", err, 0);
    check("reset_cnt", stall_cnt, 0);
    check("dump_pass", mem_dump, 1);

    // Vector table: each entry starts and ends in IDLE.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      clear_inputs();
      mem_read_exmem = vecs[i].rd;  mem_write_exmem = vecs[i].wr;
      halt_exmem = vecs[i].halt;    squash = vecs[i].sq;
      alu_exmem = vecs[i].alu;      st_data_exmem = vecs[i].st;
      reg_write_exmem = vecs[i].regw; mem_to_reg_exmem = vecs[i].m2r;
      wr_reg_exmem = vecs[i].wreg;  mem_rdata = vecs[i].rdin;
      mem_done = ~vecs[i].e_req;
      #1;
      check($sformatf("v%0d_req", i), mem_req, vecs[i].e_req);
      check($sformatf("v%0d_wr", i), mem_wr, vecs[i].e_wr);
      check($sformatf("v%0d_stall", i), stall_data, vecs[i].e_stall);
      if (vecs[i].e_req) begin
        check($sformatf("v%0d_addr", i), mem_addr, vecs[i].alu);
        check($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].st);
        @(posedge clk);
        @(negedge clk);
        mem_done = 1'b1;
        #1;
        check($sformatf("v%0d_stall_done", i), stall_data, 0);
        check($sformatf("v%0d_no_rereq", i), mem_req, 0);
      end
      @(posedge clk); #1;
      check($sformatf("v%0d_rdata", i), rdata_memwb, vecs[i].e_rdata);
      check($sformatf("v%0d_alu", i), alu_memwb, vecs[i].alu);
      check($sformatf("v%0d_regw", i), reg_write_memwb, vecs[i].e_regw);
      check($sformatf("v%0d_m2r", i), mem_to_reg_memwb, vecs[i].m2r);
      check($sformatf("v%0d_wreg", i), wr_reg_memwb, vecs[i].wreg);
    end

    // Load with mem_done three cycles after the request.
    do_reset();
    drive_load(16'h0010, 3'd4);
    stall_n = 0;
    #1;
    check("beef_req", mem_req, 1);
    check("beef_addr", mem_addr, 16'h0010);
    if (stall_data) stall_n++;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 3) begin mem_done = 1'b1; mem_rdata = 16'hBEEF; end
      #1;
      if (stall_data) stall_n++;
    end
    @(posedge clk);
    @(negedge clk);
    clear_inputs();
    #1;
    check("beef_stall_cycles", stall_n, 3);
    check("beef_rdata", rdata_memwb, 16'hBEEF);
    check("beef_m2r", mem_to_reg_memwb, 1);
    check("beef_cnt", stall_cnt, 3);
    check("beef_stall_after", stall_data, 0);
    @(posedge clk);

    // mem_done coinciding with stall_instr, stall held two extra cycles.
    @(negedge clk);
    drive_load(16'h0030, 3'd6);
    req_base = req_cnt;
    #1;
    check("hold_req", mem_req, 1);
    @(posedge clk);
    @(negedge clk);
    mem_done = 1'b1; mem_rdata = 16'hA5A5; stall_instr = 1'b1;
    #1;
    check("hold_stall_done", stall_data, 0);
    @(posedge clk);
    @(negedge clk);
    mem_done = 1'b0; mem_rdata = 16'hDEAD;
    #1;
    check("hold_x1_req", mem_req, 0);
    check("hold_x1_stall", stall_data, 0);
    check("hold_x1_rdata", rdata_memwb, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("hold_x2_rdata", rdata_memwb, 0);
    @(posedge clk);
    @(negedge clk);
    stall_instr = 1'b0;
    #1;
    check("hold_rel_req", mem_req, 0);
    @(posedge clk); #1;
    check("hold_rdata", rdata_memwb, 16'hA5A5);
    check("hold_wreg", wr_reg_memwb, 6);
    @(negedge clk);
    clear_inputs();
    repeat (2) @(posedge clk);
    check("hold_one_req", req_cnt - req_base, 1);

    // Error response, then reset in the middle of a following WAIT.
    @(negedge clk);
    drive_load(16'h0044, 3'd2);
    @(posedge clk);
    @(negedge clk);
    mem_done = 1'b1; mem_err = 1'b1; mem_rdata = 16'h3C3C;
    @(posedge clk); #1;
    check("err_set", err, 1);
    check("err_rdata", rdata_memwb, 16'h3C3C);
    @(negedge clk);
    drive_load(16'h0046, 3'd3);
    #1;
    check("err_req2", mem_req, 1);
    @(posedge clk);
    @(negedge clk); #1;
    check("err_sticky", err, 1);
    check("err_wait_stall", stall_data, 1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstw_req", mem_req, 0);
    check("rstw_stall", stall_data, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    mem_done = 1'b1; mem_rdata = 16'h7E7E;
    #1;
    check("rstw_err", err, 0);
    check("rstw_rdata", rdata_memwb, 0);
    check("rstw_alu", alu_memwb, 0);
    check("rstw_regw", reg_write_memwb, 0);
    check("rstw_m2r", mem_to_reg_memwb, 0);
    check("rstw_wreg", wr_reg_memwb, 0);
    check("rstw_cnt", stall_cnt, 0);
    check("rstw_stray_stall", stall_data, 0);
    @(posedge clk); #1;
    check("stray_rdata", rdata_memwb, 0);
    @(negedge clk);
    drive_load(16'h0048, 3'd1);
    #1;
    check("rstw_idle_req", mem_req, 1);

    // Five-cycle load: CW=2 counter saturates at 3, CW=16 counts to 5.
    do_reset();
    drive_load(16'h0080, 3'd5);
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 5) begin mem_done = 1'b1; mem_rdata = 16'h0F0F; end
      @(posedge clk); #1;
      exp_cnt = (k < 5) ? k + 1 : 5;
      check($sformatf("sat_cnt16_%0d", k), stall_cnt, exp_cnt);
      check($sformatf("sat_cnt2_%0d", k), stall_cnt2, (exp_cnt > 3) ? 3 : exp_cnt);
    end
    check("sat_rdata2", rdata_memwb2, 16'h0F0F);
    @(negedge clk);
    clear_inputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
